// File: rtl/qid_arb_pkg.sv
// qid_arb_pkg: shared types for the queue-ID arbiter.
//   state_t  - arbiter FSM states
//   ev_op_t  - control event opcodes
//   entry_t  - per-queue state table entry {enable, in_fifo, credit}
//   sat_add  - saturating credit add
// CREDIT_W fixes the entry layout; the top-level CREDIT_WIDTH must match it.
package qid_arb_pkg;

  localparam int CREDIT_W = 16;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_ISSUE, S_UPDATE
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_EN  = 2'b01,
    OP_DIS = 2'b10,
    OP_NOP = 2'b11
  } ev_op_t;

  typedef struct packed {
    logic                enable;
    logic                in_fifo;
    logic [CREDIT_W-1:0] credit;
  } entry_t;

  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                  input logic [CREDIT_W-1:0] b);
    logic [CREDIT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CREDIT_W] ? {CREDIT_W{1'b1}} : s[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/qid_state_table.sv
// qid_state_table: MAX_QUEUES x entry_t distributed RAM.
//   ev_addr/ev_rd    - async read port for the event path
//   fsm_addr/fsm_rd  - async read port for the arbiter FSM
//   init_we/init_addr - clear sweep (highest write priority)
//   upd_we/upd_data   - FSM write-back, addressed by fsm_addr
//   ev_we/ev_data     - event write-back, addressed by ev_addr
// The sweep, update and event writers never legitimately collide; the
// priority only makes the mux well defined.
module qid_state_table
  import qid_arb_pkg::*;
#(
  parameter int QUEUE_ID_WIDTH = 11,
  parameter int MAX_QUEUES     = 2048
) (
  input  logic                      clk,
  input  logic [QUEUE_ID_WIDTH-1:0] ev_addr,
  output entry_t                    ev_rd,
  input  logic [QUEUE_ID_WIDTH-1:0] fsm_addr,
  output entry_t                    fsm_rd,
  input  logic                      init_we,
  input  logic [QUEUE_ID_WIDTH-1:0] init_addr,
  input  logic                      upd_we,
  input  entry_t                    upd_data,
  input  logic                      ev_we,
  input  entry_t                    ev_data
);

  entry_t mem [MAX_QUEUES];

  always_ff @(posedge clk) begin
    if (init_we)     mem[init_addr] <= '0;
    else if (upd_we) mem[fsm_addr]  <= upd_data;
    else if (ev_we)  mem[ev_addr]   <= ev_data;
  end

  assign ev_rd  = mem[ev_addr];
  assign fsm_rd = mem[fsm_addr];

endmodule

// File: rtl/qid_arbiter.sv
// qid_arbiter: round-robin descriptor arbiter over a FWFT queue-ID FIFO.
//   ev_*        - control events (add credit / enable / disable)
//   qid_wr_*    - FIFO push (this block is the only writer)
//   qid_rd_*    - FIFO head and pop
//   req_*       - descriptor fetch request, up to MAX_BURST descriptors
//   init_done   - state table clear sweep finished
// A qid is in the FIFO iff its in_fifo bit is set, which holds from push
// until the S_UPDATE that decides not to requeue it.
module qid_arbiter
  import qid_arb_pkg::*;
#(
  parameter int QUEUE_ID_WIDTH = 11,
  parameter int MAX_QUEUES     = 2048,
  parameter int CREDIT_WIDTH   = CREDIT_W,
  parameter int BURST_WIDTH    = 6,
  parameter int MAX_BURST      = 32
) (
  input  logic                      user_clk,
  input  logic                      user_reset_n,
  input  logic                      ev_vld,
  output logic                      ev_rdy,
  input  logic [1:0]                ev_op,
  input  logic [QUEUE_ID_WIDTH-1:0] ev_qid,
  input  logic [CREDIT_WIDTH-1:0]   ev_credit,
  output logic [QUEUE_ID_WIDTH-1:0] qid_wr_data,
  output logic                      qid_wr_en,
  input  logic [QUEUE_ID_WIDTH-1:0] qid_rd_data,
  input  logic                      qid_rd_vld,
  output logic                      qid_rd_en,
  output logic                      req_vld,
  input  logic                      req_rdy,
  output logic [QUEUE_ID_WIDTH-1:0] req_qid,
  output logic [BURST_WIDTH-1:0]    req_num,
  output logic                      init_done
);

  localparam logic [QUEUE_ID_WIDTH-1:0] LAST_Q = QUEUE_ID_WIDTH'(MAX_QUEUES - 1);

  state_t                    state;
  logic [QUEUE_ID_WIDTH-1:0] init_cnt;
  logic [QUEUE_ID_WIDTH-1:0] cur_qid;
  logic [BURST_WIDTH-1:0]    num;
  entry_t                    ev_ent, fsm_ent, ev_new, upd_new;
  logic                      ev_fire, ev_push, upd_push;
  logic [BURST_WIDTH-1:0]    lk_num;
  logic [CREDIT_WIDTH-1:0]   num_ext;

  assign ev_rdy    = (state != S_INIT) && (state != S_UPDATE);
  assign ev_fire   = ev_vld && ev_rdy;
  assign qid_rd_en = (state == S_IDLE) && qid_rd_vld;
  assign req_qid   = cur_qid;
  assign req_num   = num;
  assign num_ext   = {{(CREDIT_WIDTH-BURST_WIDTH){1'b0}}, num};
  assign lk_num    = (fsm_ent.credit >= CREDIT_WIDTH'(MAX_BURST)) ?
                     BURST_WIDTH'(MAX_BURST) : fsm_ent.credit[BURST_WIDTH-1:0];

  // Event path: apply the op, then decide the push on the post-update entry.
  always_comb begin
    ev_new = ev_ent;
    case (ev_op_t'(ev_op))
      OP_ADD:  ev_new.credit = sat_add(ev_ent.credit, ev_credit);
      OP_EN:   begin ev_new.enable = 1'b1; ev_new.credit = '0; end
      OP_DIS:  begin ev_new.enable = 1'b0; ev_new.credit = '0; end
      default: ;
    endcase
    ev_push = ev_fire && ev_new.enable && !ev_new.in_fifo && (ev_new.credit != '0);
    if (ev_push) ev_new.in_fifo = 1'b1;
  end

  // Write-back for S_UPDATE. A re-enable during the grant zeroes credit under
  // us, so the decrement floors at zero rather than wrapping.
  always_comb begin
    upd_new = fsm_ent;
    if (fsm_ent.enable)
      upd_new.credit = (fsm_ent.credit > num_ext) ? fsm_ent.credit - num_ext : '0;
    upd_push        = fsm_ent.enable && (upd_new.credit != '0);
    upd_new.in_fifo = upd_push;
  end

  qid_state_table #(
    .QUEUE_ID_WIDTH (QUEUE_ID_WIDTH),
    .MAX_QUEUES     (MAX_QUEUES)
  ) u_table (
    .clk       (user_clk),
    .ev_addr   (ev_qid),
    .ev_rd     (ev_ent),
    .fsm_addr  (cur_qid),
    .fsm_rd    (fsm_ent),
    .init_we   (state == S_INIT),
    .init_addr (init_cnt),
    .upd_we    (state == S_UPDATE),
    .upd_data  (upd_new),
    .ev_we     (ev_fire),
    .ev_data   (ev_new)
  );

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      state       <= S_INIT;
      init_cnt    <= '0;
      init_done   <= 1'b0;
      cur_qid     <= '0;
      num         <= '0;
      req_vld     <= 1'b0;
      qid_wr_en   <= 1'b0;
      qid_wr_data <= '0;
    end else begin
      // Event push and requeue push never coincide: events are blocked in S_UPDATE.
      qid_wr_en <= 1'b0;
      if (ev_push) begin
        qid_wr_en   <= 1'b1;
        qid_wr_data <= ev_qid;
      end
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_Q) begin
            init_done <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_IDLE: if (qid_rd_vld) begin
          cur_qid <= qid_rd_data;
          state   <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (fsm_ent.enable && (fsm_ent.credit != '0)) begin
            num     <= lk_num;
            req_vld <= 1'b1;
            state   <= S_ISSUE;
          end else begin
            num   <= '0;
            state <= S_UPDATE;
          end
        end
        S_ISSUE: if (req_rdy) begin
          req_vld <= 1'b0;
          state   <= S_UPDATE;
        end
        S_UPDATE: begin
          if (upd_push) begin
            qid_wr_en   <= 1'b1;
            qid_wr_data <= cur_qid;
          end
          state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_qid_arbiter.sv
module tb_qid_arbiter;
  localparam int QW = 11;
  localparam int CW = 16;
  localparam int BW = 6;
  localparam logic [1:0] E_ADD = 2'b00, E_EN = 2'b01, E_DIS = 2'b10;

  logic          user_clk = 1'b0;
  logic          user_reset_n = 1'b0;
  logic          ev_vld = 1'b0, ev_rdy;
  logic [1:0]    ev_op = 2'b11;
  logic [QW-1:0] ev_qid = '0;
  logic [CW-1:0] ev_credit = '0;
  logic [QW-1:0] qid_wr_data, qid_rd_data;
  logic          qid_wr_en, qid_rd_vld, qid_rd_en;
  logic          req_vld, req_rdy = 1'b0;
  logic [QW-1:0] req_qid;
  logic [BW-1:0] req_num;
  logic          init_done;

  int errors = 0;
  int checks = 0;

  always #5 user_clk = ~user_clk;

  qid_arbiter dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n),
    .ev_vld(ev_vld), .ev_rdy(ev_rdy), .ev_op(ev_op), .ev_qid(ev_qid), .ev_credit(ev_credit),
    .qid_wr_data(qid_wr_data), .qid_wr_en(qid_wr_en),
    .qid_rd_data(qid_rd_data), .qid_rd_vld(qid_rd_vld), .qid_rd_en(qid_rd_en),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_qid(req_qid), .req_num(req_num),
    .init_done(init_done)
  );

  // FWFT FIFO model sharing the arbiter's reset.
  logic [QW-1:0] fmem [2048];
  logic [QW:0]   fcnt = '0;
  logic [QW-1:0] frd = '0, fwr = '0;
  bit            fov = 1'b0;
  assign qid_rd_vld  = (fcnt != '0);
  assign qid_rd_data = fmem[frd];

  always @(posedge user_clk) begin
    if (!user_reset_n) begin
      fcnt <= '0; frd <= '0; fwr <= '0;
    end else begin
      if (qid_wr_en) begin
        if (fcnt == 12'd2048) fov <= 1'b1;
        fmem[fwr] <= qid_wr_data;
        fwr <= fwr + 1'b1;
      end
      if (qid_rd_en) frd <= frd + 1'b1;
      fcnt <= fcnt + {{QW{1'b0}}, qid_wr_en} - {{QW{1'b0}}, qid_rd_en};
    end
  end

  // Observers: handshakes, pushes per qid, duplicate-in-FIFO detection.
  logic [QW-1:0] rq_q [$];
  logic [BW-1:0] rn_q [$];
  int            push_cnt [2048];
  bit            intb [2048];
  int            dup_cnt = 0;

  always @(negedge user_clk) begin
    if (!user_reset_n) begin
      intb = '{default: 1'b0};
    end else begin
      if (qid_rd_en) intb[qid_rd_data] = 1'b0;
      if (qid_wr_en) begin
        if (intb[qid_wr_data]) dup_cnt++;
        intb[qid_wr_data] = 1'b1;
        push_cnt[qid_wr_data]++;
      end
      if (req_vld && req_rdy) begin
        rq_q.push_back(req_qid);
        rn_q.push_back(req_num);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge user_clk);
    #1;
  endtask

  task automatic send_ev(input logic [1:0] op, input logic [QW-1:0] q, input logic [CW-1:0] c);
    int w = 0;
    ev_vld = 1'b1; ev_op = op; ev_qid = q; ev_credit = c;
    while (!ev_rdy && w < 100) begin tick(1); w++; end
    chk("ev_accept", 32'(ev_rdy), 32'd1);
    tick(1);
    ev_vld = 1'b0;
  endtask

  task automatic wait_reqs(input string tag, input int target, input int budget);
    int w = 0;
    while (rq_q.size() < target && w < budget) begin tick(1); w++; end
    chk({tag, "_reqs"}, 32'(rq_q.size() >= target), 32'd1);
  endtask

  task automatic wait_vld(input string tag);
    int w = 0;
    while (!req_vld && w < 100) begin tick(1); w++; end
    chk({tag, "_vld"}, 32'(req_vld), 32'd1);
  endtask

  task automatic run_init(input string tag);
    bit seen = 1'b0;
    user_reset_n = 1'b1;
    for (int i = 0; i < 2047; i++) begin
      tick(1);
      if (ev_rdy || qid_wr_en || qid_rd_en || req_vld) seen = 1'b1;
    end
    chk({tag, "_quiet"}, 32'(seen), 32'd0);
    chk({tag, "_done_early"}, 32'(init_done), 32'd0);
    tick(1);
    chk({tag, "_done"}, 32'(init_done), 32'd1);
    chk({tag, "_ev_rdy"}, 32'(ev_rdy), 32'd1);
  endtask

  initial begin
    int base;
    int sum;

    // Reset and init sweep
    tick(3);
    chk("rst_outs", 32'({ev_rdy, qid_wr_en, qid_rd_en, req_vld, init_done}), 32'd0);
    run_init("init");

    // q5: 70 credits -> 32, 32, 6
    req_rdy = 1'b1;
    base = rq_q.size();
    send_ev(E_EN, 11'd5, '0);
    send_ev(E_ADD, 11'd5, 16'd70);
    chk("q5_push_strobe", 32'({qid_wr_en, qid_wr_data}), 32'({1'b1, 11'd5}));
    tick(1);
    chk("q5_pop", 32'(qid_rd_en), 32'd1);
    tick(2);
    chk("q5_req_lat", 32'({req_vld, req_qid, req_num}), 32'({1'b1, 11'd5, 6'd32}));
    wait_reqs("q5", base + 3, 200);
    tick(20);
    chk("q5_count", 32'(rq_q.size() - base), 32'd3);
    chk("q5_r0", 32'({rq_q[base], rn_q[base]}), 32'({11'd5, 6'd32}));
    chk("q5_r1", 32'({rq_q[base+1], rn_q[base+1]}), 32'({11'd5, 6'd32}));
    chk("q5_r2", 32'({rq_q[base+2], rn_q[base+2]}), 32'({11'd5, 6'd6}));
    chk("q5_pushes", 32'(push_cnt[5]), 32'd3);
    chk("q5_fifo_empty", 32'(fcnt), 32'd0);
    // in_fifo(5) was cleared, so one more credit must push and grant again
    send_ev(E_ADD, 11'd5, 16'd1);
    wait_reqs("q5b", base + 4, 50);
    chk("q5_refill", 32'({rq_q[base+3], rn_q[base+3]}), 32'({11'd5, 6'd1}));
    chk("q5_pushes2", 32'(push_cnt[5]), 32'd4);

    // q1/q2 round robin with 40 credits each
    tick(10);
    base = rq_q.size();
    send_ev(E_EN, 11'd1, '0);
    send_ev(E_EN, 11'd2, '0);
    send_ev(E_ADD, 11'd1, 16'd40);
    send_ev(E_ADD, 11'd2, 16'd40);
    wait_reqs("rr", base + 4, 200);
    tick(20);
    chk("rr_count", 32'(rq_q.size() - base), 32'd4);
    chk("rr_0", 32'({rq_q[base], rn_q[base]}), 32'({11'd1, 6'd32}));
    chk("rr_1", 32'({rq_q[base+1], rn_q[base+1]}), 32'({11'd2, 6'd32}));
    chk("rr_2", 32'({rq_q[base+2], rn_q[base+2]}), 32'({11'd1, 6'd8}));
    chk("rr_3", 32'({rq_q[base+3], rn_q[base+3]}), 32'({11'd2, 6'd8}));
    chk("rr_fifo_empty", 32'(fcnt), 32'd0);

    // q3 saturation: 0xFFF0 + 0x0100 clamps to 0xFFFF = 2047*32 + 31
    base = rq_q.size();
    send_ev(E_EN, 11'd3, '0);
    send_ev(E_ADD, 11'd3, 16'hFFF0);
    send_ev(E_ADD, 11'd3, 16'h0100);
    wait_reqs("sat", base + 2048, 20000);
    tick(20);
    sum = 0;
    for (int i = base; i < rq_q.size(); i++) sum += int'(rn_q[i]);
    chk("sat_count", 32'(rq_q.size() - base), 32'd2048);
    chk("sat_sum", 32'(sum), 32'hFFFF);
    chk("sat_last", 32'(rn_q[rq_q.size()-1]), 32'd31);
    chk("sat_pushes", 32'(push_cnt[3]), 32'd2048);

    // q7: request held, disabled mid-wait, completes without requeue
    req_rdy = 1'b0;
    base = rq_q.size();
    send_ev(E_EN, 11'd7, '0);
    send_ev(E_ADD, 11'd7, 16'd40);
    wait_vld("q7");
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        ev_vld = 1'b1; ev_op = E_DIS; ev_qid = 11'd7; ev_credit = '0;
      end else begin
        ev_vld = 1'b0;
      end
      tick(1);
      chk("q7_hold", 32'({req_vld, req_qid, req_num}), 32'({1'b1, 11'd7, 6'd32}));
    end
    ev_vld = 1'b0;
    req_rdy = 1'b1;
    tick(1);
    req_rdy = 1'b0;
    tick(30);
    chk("q7_count", 32'(rq_q.size() - base), 32'd1);
    chk("q7_no_requeue", 32'(push_cnt[7]), 32'd1);
    chk("q7_fifo_empty", 32'(fcnt), 32'd0);
    chk("q7_idle", 32'(req_vld), 32'd0);

    // q9: credit added while in S_ISSUE is kept, no duplicate push
    base = rq_q.size();
    send_ev(E_EN, 11'd9, '0);
    send_ev(E_ADD, 11'd9, 16'd40);
    wait_vld("q9");
    chk("q9_first", 32'({req_qid, req_num}), 32'({11'd9, 6'd32}));
    send_ev(E_ADD, 11'd9, 16'd10);
    tick(3);
    chk("q9_no_dup_push", 32'(push_cnt[9]), 32'd1);
    chk("q9_fifo", 32'(fcnt), 32'd0);
    req_rdy = 1'b1;
    wait_reqs("q9", base + 2, 100);
    tick(20);
    chk("q9_second", 32'({rq_q[base+1], rn_q[base+1]}), 32'({11'd9, 6'd18}));
    chk("q9_count", 32'(rq_q.size() - base), 32'd2);
    chk("q9_pushes", 32'(push_cnt[9]), 32'd2);

    // Reset while in S_ISSUE
    req_rdy = 1'b0;
    base = rq_q.size();
    send_ev(E_EN, 11'd11, '0);
    send_ev(E_ADD, 11'd11, 16'd5);
    wait_vld("q11");
    user_reset_n = 1'b0;
    tick(1);
    chk("rst_issue_outs", 32'({req_vld, ev_rdy, init_done, qid_wr_en, qid_rd_en}), 32'd0);
    tick(1);
    run_init("reinit");
    req_rdy = 1'b1;
    tick(20);
    chk("reinit_no_req", 32'(rq_q.size() - base), 32'd0);
    chk("reinit_fifo", 32'(fcnt), 32'd0);

    chk("no_dup_in_fifo", 32'(dup_cnt), 32'd0);
    chk("no_fifo_overflow", 32'(fov), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
